// File: rtl/board_io_conditioner_if.sv
// board_io_conditioner_if: pin-side inputs and conditioned outputs of the board front end
interface board_io_conditioner_if #(
    parameter int NBUTTONS  = 2,
    parameter int NSWITCHES = 3
);
    logic [NBUTTONS-1:0]  nbut;
    logic [NSWITCHES-1:0] sw;
    logic                 tick;
    logic [NBUTTONS-1:0]  but_level;
    logic [NBUTTONS-1:0]  but_press;
    logic [NBUTTONS-1:0]  but_release;
    logic [NBUTTONS-1:0]  but_long;
    logic [NSWITCHES-1:0] sw_level;
    logic [NSWITCHES-1:0] sw_change;
    logic                 por_n;

    modport master (
        output nbut, sw,
        input  tick, but_level, but_press, but_release, but_long, sw_level, sw_change, por_n
    );

    modport slave (
        input  nbut, sw,
        output tick, but_level, but_press, but_release, but_long, sw_level, sw_change, por_n
    );
endinterface

// File: rtl/board_io_conditioner.sv
// board_io_conditioner: clock-enable tick, debounced buttons/switches with edge and long-press pulses, timed core reset release
module board_io_conditioner #(
    parameter int CLK_DIV    = 4,
    parameter int NBUTTONS   = 2,
    parameter int NSWITCHES  = 3,
    parameter int DEB_TICKS  = 16,
    parameter int LONG_TICKS = 1000,
    parameter int POR_TICKS  = 64
) (
    input logic clk,
    input logic nRESET,
    board_io_conditioner_if.slave io
);
    localparam int nch = NBUTTONS + NSWITCHES;
    localparam int dw  = $clog2(CLK_DIV + 1);
    localparam int cw  = $clog2(DEB_TICKS + 1);
    localparam int hw  = $clog2(LONG_TICKS + 1);
    localparam int pw  = $clog2(POR_TICKS + 1);
    localparam logic [dw-1:0] div_max  = dw'(CLK_DIV - 1);
    localparam logic [cw-1:0] deb_max  = cw'(DEB_TICKS - 1);
    localparam logic [hw-1:0] long_max = hw'(LONG_TICKS);
    localparam logic [hw-1:0] long_pre = hw'(LONG_TICKS - 1);
    localparam logic [pw-1:0] por_max  = pw'(POR_TICKS - 1);

    logic [dw-1:0]       div_cnt;
    logic                en;
    logic [pw-1:0]       pcnt;
    logic [nch-1:0]      raw, s1, s2, level, rise, fall, flip;
    logic [cw-1:0]       dcnt [nch];
    logic [hw-1:0]       hcnt [NBUTTONS];
    logic [NBUTTONS-1:0] lng;

    // en marks the edge on which the registered tick output rises; all tick-paced counters advance on it
    assign en  = div_cnt == div_max;
    assign raw = {io.sw, ~io.nbut};

    // divider, tick output and power-on reset release
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            div_cnt  <= '0;
            io.tick  <= 1'b0;
            pcnt     <= '0;
            io.por_n <= 1'b0;
        end else begin
            div_cnt <= en ? '0 : div_cnt + 1'b1;
            io.tick <= en;
            if (en && !io.por_n) begin
                pcnt <= pcnt + 1'b1;
                if (pcnt == por_max) io.por_n <= 1'b1;
            end
        end
    end

    // a channel flips on the tick that completes DEB_TICKS of stable disagreement
    always_comb begin
        for (int i = 0; i < nch; i++) flip[i] = en && (s2[i] != level[i]) && (dcnt[i] == deb_max);
    end

    // two-flop synchroniser, debounce counters, levels and edge pulses
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            s1    <= '0;
            s2    <= '0;
            level <= '0;
            rise  <= '0;
            fall  <= '0;
            for (int i = 0; i < nch; i++) dcnt[i] <= '0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            level <= level ^ flip;
            rise  <= flip & ~level;
            fall  <= flip & level;
            for (int i = 0; i < nch; i++)
                dcnt[i] <= (s2[i] == level[i] || flip[i]) ? '0 : en ? dcnt[i] + 1'b1 : dcnt[i];
        end
    end

    // hold counters saturate at LONG_TICKS so the long pulse fires once per press
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            lng <= '0;
            for (int i = 0; i < NBUTTONS; i++) hcnt[i] <= '0;
        end else begin
            for (int i = 0; i < NBUTTONS; i++) begin
                hcnt[i] <= !level[i] ? '0 : (en && hcnt[i] != long_max) ? hcnt[i] + 1'b1 : hcnt[i];
                lng[i]  <= level[i] && en && (hcnt[i] == long_pre);
            end
        end
    end

    assign io.but_level   = level[NBUTTONS-1:0];
    assign io.but_press   = rise[NBUTTONS-1:0];
    assign io.but_release = fall[NBUTTONS-1:0];
    assign io.but_long    = lng;
    assign io.sw_level    = level[nch-1:NBUTTONS];
    assign io.sw_change   = rise[nch-1:NBUTTONS] | fall[nch-1:NBUTTONS];
endmodule

// File: tb/tb_board_io_conditioner.sv
// tb_board_io_conditioner: step table and hand sequences scored against an expected pulse-event queue
module tb_board_io_conditioner;
    localparam int NB = 2;
    localparam int NS = 3;

    typedef struct {
        int kind;
        int ch;
        int cyc;
    } ev_t;

    typedef struct {
        int   ch;
        logic val;
        int   ticks;
        logic chg;
        logic lng;
    } step_t;

    logic clk = 1'b0;
    logic nRESET = 1'b0;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    ev_t exp_q[$];
    ev_t obs_q[$];
    step_t steps[12];
    logic [NB+NS-1:0] lv = '0;

    board_io_conditioner_if #(.NBUTTONS(NB), .NSWITCHES(NS)) io ();

    board_io_conditioner #(
        .CLK_DIV(4), .NBUTTONS(NB), .NSWITCHES(NS),
        .DEB_TICKS(16), .LONG_TICKS(1000), .POR_TICKS(64)
    ) dut (
        .clk(clk),
        .nRESET(nRESET),
        .io(io)
    );

    always #5 clk = ~clk;

    // edges since the last reset release
    always @(posedge clk or negedge nRESET) cyc <= !nRESET ? 0 : cyc + 1;

    // record every pulse and check tick / por_n against the divider timeline
    always @(negedge clk) begin
        if (nRESET) begin
            for (int b = 0; b < NB; b++) begin
                if (io.but_press[b])   obs_q.push_back('{0, b, cyc});
                if (io.but_release[b]) obs_q.push_back('{1, b, cyc});
                if (io.but_long[b])    obs_q.push_back('{2, b, cyc});
            end
            for (int s = 0; s < NS; s++)
                if (io.sw_change[s]) obs_q.push_back('{3, s, cyc});
            checks += 2;
            if (io.tick !== (cyc % 4 == 0 && cyc != 0)) begin
                errors++;
                $display("FAIL tick cyc=%0d got %b want %b", cyc, io.tick, (cyc % 4 == 0 && cyc != 0));
            end
            if (io.por_n !== (cyc >= 256)) begin
                errors++;
                $display("FAIL por_n cyc=%0d got %b want %b", cyc, io.por_n, (cyc >= 256));
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            ev_t e = exp_q.pop_front();
            ev_t o = obs_q.pop_front();
            checks++;
            if (e.kind != o.kind || e.ch != o.ch || e.cyc != o.cyc) begin
                errors++;
                $display("FAIL %s event got kind%0d ch%0d cyc%0d want kind%0d ch%0d cyc%0d",
                         tag, o.kind, o.ch, o.cyc, e.kind, e.ch, e.cyc);
            end
        end
        check({tag, "_missing"}, exp_q.size(), 0);
        check({tag, "_extra"}, obs_q.size(), 0);
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic drive(input int ch, input logic val);
        if (ch < NB) io.nbut[ch] = ~val;
        else io.sw[ch-NB] = val;
    endtask

    function automatic logic [31:0] all_outs();
        return {16'd0, io.tick, io.por_n, io.but_level, io.but_press, io.but_release,
                io.but_long, io.sw_level, io.sw_change};
    endfunction

    // edge at which a level change driven just after edge c appears: 2-flop sync, then 16 ticks
    function automatic int deb_edge(input int c);
        return ((c + 6) / 4) * 4 + 60;
    endfunction

    initial begin
        int c, e;
        steps[0]  = '{0, 1'b1, 40,   1'b1, 1'b0};
        steps[1]  = '{0, 1'b0, 40,   1'b1, 1'b0};
        steps[2]  = '{0, 1'b1, 1100, 1'b1, 1'b1};
        steps[3]  = '{0, 1'b0, 40,   1'b1, 1'b0};
        steps[4]  = '{0, 1'b1, 900,  1'b1, 1'b0};
        steps[5]  = '{0, 1'b0, 40,   1'b1, 1'b0};
        steps[6]  = '{4, 1'b1, 40,   1'b1, 1'b0};
        steps[7]  = '{4, 1'b0, 40,   1'b1, 1'b0};
        steps[8]  = '{1, 1'b1, 40,   1'b1, 1'b0};
        steps[9]  = '{1, 1'b0, 40,   1'b1, 1'b0};
        steps[10] = '{2, 1'b1, 10,   1'b0, 1'b0};
        steps[11] = '{2, 1'b0, 40,   1'b0, 1'b0};
        io.nbut = '1;
        io.sw   = '0;
        repeat (3) begin
            @(negedge clk);
            check("reset_outputs", all_outs(), 0);
        end
        nRESET = 1'b1;
        repeat (260) @(negedge clk);
        drain("por_idle");

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(steps[i].ch, steps[i].val);
            c = cyc;
            e = deb_edge(c);
            if (steps[i].chg) begin
                lv[steps[i].ch] = steps[i].val;
                if (steps[i].ch < NB) exp_q.push_back('{steps[i].val ? 0 : 1, steps[i].ch, e});
                else exp_q.push_back('{3, steps[i].ch - NB, e});
            end
            if (steps[i].lng) exp_q.push_back('{2, steps[i].ch, e + 4000});
            repeat (steps[i].ticks * 4) @(negedge clk);
            drain($sformatf("step%0d", i));
            check($sformatf("step%0d_levels", i), {27'd0, io.sw_level, io.but_level}, {27'd0, lv});
        end

        for (int t = 0; t < 40; t++) begin
            repeat (20) @(negedge clk);
            io.nbut[1] = ~io.nbut[1];
        end
        repeat (80) @(negedge clk);
        drain("glitch");
        check("glitch_level", io.but_level[1], 0);

        @(negedge clk);
        drive(0, 1'b1);
        exp_q.push_back('{0, 0, deb_edge(cyc)});
        repeat (160) @(negedge clk);
        drain("pre_reset_press");
        check("pre_reset_level", io.but_level[0], 1);
        nRESET = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("midrun_reset_outputs", all_outs(), 0);
        end
        nRESET = 1'b1;
        exp_q.push_back('{0, 0, 64});
        repeat (300) @(negedge clk);
        drain("post_reset_press");
        check("post_reset_level", io.but_level[0], 1);
        check("post_reset_por", io.por_n, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
